// File: rtl/mdu_scheduler_if.sv
// Handshake and data bundle between the E/D pipeline stages and the multiply/divide unit.
// The master side is the pipeline, which drives the issue and move requests and the D-stage use flag.
// The slave side is the MDU, which drives HI/LO, busy and the D-stage stall request.
interface mdu_scheduler_if;
  logic        E_start;
  logic [2:0]  E_op;
  logic        E_adv;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        E_mthi;
  logic        E_mtlo;
  logic        D_md_use;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        D_md_stall;

  modport master (
    output E_start, E_op, E_adv, E_rs, E_rt, E_mthi, E_mtlo, D_md_use,
    input  hi, lo, busy, D_md_stall
  );

  modport slave (
    input  E_start, E_op, E_adv, E_rs, E_rt, E_mthi, E_mtlo, D_md_use,
    output hi, lo, busy, D_md_stall
  );
endinterface

// File: rtl/mdu_scheduler.sv
// Multi-cycle mult/multu/div/divu (and madd when MDU_MADD_EN is defined) controller beside E, owning HI/LO.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles after the issuing edge; mthi/mtlo take effect at the next edge.
// Backpressure: no ready signal; D_md_stall asks the hazard unit to hold F/D while an md instr in D would hit a pending HI/LO.
module mdu_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic            clk,
  input logic            reset,
  mdu_scheduler_if.slave mdu
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_opa;
  logic [31:0]      r_opb;
  logic [2:0]       r_opr;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic             w_op_ok;
  logic             w_is_div;
  logic             w_fire;
  logic             w_done;
  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;
  logic [31:0]      w_quo_s;
  logic [31:0]      w_rem_s;
  logic [31:0]      w_quo_u;
  logic [31:0]      w_rem_u;
  logic             w_div_zero;
`ifdef MDU_MADD_EN
  logic [63:0]      w_madd;
`endif

  // Classify the E-stage op: which codes start an operation and which ones take the divide latency.
  always_comb begin
    w_op_ok  = 1'b0;
    w_is_div = 1'b0;
    case (mdu.E_op)
      3'b000, 3'b001: w_op_ok = 1'b1;
      3'b010, 3'b011: begin
        w_op_ok  = 1'b1;
        w_is_div = 1'b1;
      end
`ifdef MDU_MADD_EN
      3'b100: w_op_ok = 1'b1;
`endif
      default: w_op_ok = 1'b0;
    endcase
  end

  // A new op is accepted only when idle; reserved codes never leave IDLE.
  assign w_fire = mdu.E_start & mdu.E_adv & (r_state == S_IDLE) & w_op_ok;

  // Arithmetic on the latched operands; sign-extending to 64 bits makes the low 64 product bits the signed product.
  assign w_prod_s   = {{32{r_opa[31]}}, r_opa} * {{32{r_opb[31]}}, r_opb};
  assign w_prod_u   = {32'd0, r_opa} * {32'd0, r_opb};
  assign w_div_zero = (r_opb == 32'd0);
  assign w_quo_s    = w_div_zero ? 32'd0 : 32'($signed(r_opa) / $signed(r_opb));
  assign w_rem_s    = w_div_zero ? 32'd0 : 32'($signed(r_opa) % $signed(r_opb));
  assign w_quo_u    = w_div_zero ? 32'd0 : r_opa / r_opb;
  assign w_rem_u    = w_div_zero ? 32'd0 : r_opa % r_opb;
`ifdef MDU_MADD_EN
  // madd accumulates onto the HI/LO value present at completion, not at issue.
  assign w_madd     = {r_hi, r_lo} + w_prod_s;
`endif

  // Next-state logic: load the latency on issue, count down while busy, finish on the cnt==1 edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_is_div ? DIV_N : MULT_N;
        end
      end
      S_BUSY: begin
        if (r_cnt == CNT_1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // HI/LO update: results land on the completion edge; moves are honoured only while idle.
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (w_done) begin
      case (r_opr)
        3'b000: {w_hi_nxt, w_lo_nxt} = w_prod_s;
        3'b001: {w_hi_nxt, w_lo_nxt} = w_prod_u;
        3'b010: if (!w_div_zero) begin
          w_hi_nxt = w_rem_s;
          w_lo_nxt = w_quo_s;
        end
        3'b011: if (!w_div_zero) begin
          w_hi_nxt = w_rem_u;
          w_lo_nxt = w_quo_u;
        end
`ifdef MDU_MADD_EN
        3'b100: {w_hi_nxt, w_lo_nxt} = w_madd;
`endif
        default: begin
          w_hi_nxt = r_hi;
          w_lo_nxt = r_lo;
        end
      endcase
    end else if ((r_state == S_IDLE) && mdu.E_adv) begin
      if (mdu.E_mthi) w_hi_nxt = mdu.E_rs;
      if (mdu.E_mtlo) w_lo_nxt = mdu.E_rs;
    end
  end

  // State and counter registers; reset abandons any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Operand latch on issue, plus the architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opa <= '0;
      r_opb <= '0;
      r_opr <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_fire) begin
        r_opa <= mdu.E_rs;
        r_opb <= mdu.E_rt;
        r_opr <= mdu.E_op;
      end
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign mdu.hi         = r_hi;
  assign mdu.lo         = r_lo;
  assign mdu.busy       = (r_state == S_BUSY);
  // The issuing cycle is covered by E_start & E_adv, before busy has had a chance to rise.
  assign mdu.D_md_stall = mdu.D_md_use & ((r_state == S_BUSY) | (mdu.E_start & mdu.E_adv));

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed and random bench for mdu_scheduler against an arithmetic HI/LO reference model.
// Each op is checked cycle by cycle for busy/stall, and HI/LO are checked before and after completion.
// Define MDU_MADD_EN consistently for the bench and the design to cover the madd build.
module tb_mdu_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_scheduler_if bus();

  mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: new HI/LO and latency (0 = op does not start) from the op definitions.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] nhi, output logic [31:0] nlo, output int lat);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     r64;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = a;
    ub  = b;
    nhi = hi;
    nlo = lo;
    lat = 0;
    case (op)
      3'd0: begin r64 = sa * sb; {nhi, nlo} = r64; lat = MC; end
      3'd1: begin r64 = ua * ub; {nhi, nlo} = r64; lat = MC; end
      3'd2: begin
        lat = DC;
        if (b != 0) begin
          r64 = sa / sb; nlo = r64[31:0];
          r64 = sa % sb; nhi = r64[31:0];
        end
      end
      3'd3: begin
        lat = DC;
        if (b != 0) begin nlo = a / b; nhi = a % b; end
      end
`ifdef MDU_MADD_EN
      3'd4: begin r64 = {hi, lo} + 64'(sa * sb); {nhi, nlo} = r64; lat = MC; end
`endif
      default: lat = 0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.E_start = 1'b0; bus.E_op = 3'd0; bus.E_adv = 1'b1; bus.E_rs = '0; bus.E_rt = '0;
    bus.E_mthi = 1'b0; bus.E_mtlo = 1'b0; bus.D_md_use = 1'b0;
  endtask

  // Issue one op and follow it to completion; poke re-asserts E_start mid-op, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic adv, input bit poke);
    logic [31:0] ehi, elo;
    int lat;
    model(op, a, b, m_hi, m_lo, ehi, elo, lat);
    if (!adv) lat = 0;
    @(negedge clk);
    bus.E_start = 1'b1; bus.E_op = op; bus.E_rs = a; bus.E_rt = b;
    bus.E_adv = adv; bus.D_md_use = use_d;
    #1;
    chk("stall_issue", 32'(bus.D_md_stall), 32'(use_d & adv));
    chk("busy_issue", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.E_start = 1'b0; bus.E_adv = 1'b1;
    if (lat == 0) begin
      chk("busy_noissue", 32'(bus.busy), 32'd0);
      chk("hi_noissue", bus.hi, m_hi);
      chk("lo_noissue", bus.lo, m_lo);
      bus.D_md_use = 1'b0;
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      bus.E_start = 1'b0;
      #1;
      chk($sformatf("busy_c%0d", k), 32'(bus.busy), 32'd1);
      chk($sformatf("stall_c%0d", k), 32'(bus.D_md_stall), 32'(use_d));
      chk($sformatf("hi_hold_c%0d", k), bus.hi, m_hi);
      if (poke && k == 2) begin
        bus.E_start = 1'b1; bus.E_op = 3'd1; bus.E_rs = 32'h0BAD_0BAD; bus.E_rt = 32'h3;
      end
      @(negedge clk);
    end
    bus.E_start = 1'b0;
    #1;
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("stall_done", 32'(bus.D_md_stall), 32'd0);
    chk("hi_done", bus.hi, ehi);
    chk("lo_done", bus.lo, elo);
    m_hi = ehi;
    m_lo = elo;
    bus.D_md_use = 1'b0;
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] v);
    @(negedge clk);
    bus.E_mthi = to_hi; bus.E_mtlo = !to_hi; bus.E_rs = v; bus.E_adv = 1'b1;
    @(negedge clk);
    bus.E_mthi = 1'b0; bus.E_mtlo = 1'b0;
    if (to_hi) m_hi = v; else m_lo = v;
    chk(to_hi ? "mthi" : "mtlo", to_hi ? bus.hi : bus.lo, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_hi     = '0;
    m_lo     = '0;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_stall", 32'(bus.D_md_stall), 32'd0);
    reset = 1'b0;

    // 1: signed multiply of -1 by 2
    run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, 0);
    chk("t1_hi", bus.hi, 32'hFFFF_FFFF);
    chk("t1_lo", bus.lo, 32'hFFFF_FFFE);
    // 2: unsigned multiply
    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b1, 0);
    chk("t2_hi", bus.hi, 32'h0000_0001);
    chk("t2_lo", bus.lo, 32'hFFFF_FFFE);
    // 3: signed divide with D-stage md instr waiting
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b1, 0);
    chk("t3_hi", bus.hi, 32'hFFFF_FFFF);
    chk("t3_lo", bus.lo, 32'hFFFF_FFFD);
    // 4: divide by zero keeps HI/LO
    mt(1'b0, 32'h1234_5678);
    run_op(3'd3, 32'h55, 32'h0, 1'b0, 1'b1, 0);
    chk("t4_lo", bus.lo, 32'h1234_5678);
    chk("t4_hi", bus.hi, 32'hFFFF_FFFF);

    // 5: reset in the third busy cycle drops the result and clears HI/LO
    @(negedge clk);
    bus.E_start = 1'b1; bus.E_op = 3'd0; bus.E_rs = 32'h7; bus.E_rt = 32'h9;
    @(negedge clk);
    bus.E_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_hi", bus.hi, 32'd0);
    chk("t5_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_busy_late", 32'(bus.busy), 32'd0);
    chk("t5_lo_late", bus.lo, 32'd0);
    m_hi = '0;
    m_lo = '0;

    // 6: madd (or reserved op without the feature)
    mt(1'b1, 32'h0);
    mt(1'b0, 32'h5);
    run_op(3'd4, 32'h3, 32'h4, 1'b1, 1'b1, 0);
`ifdef MDU_MADD_EN
    chk("t6_lo", bus.lo, 32'h0000_0011);
`else
    chk("t6_lo", bus.lo, 32'h0000_0005);
`endif
    chk("t6_hi", bus.hi, 32'h0);

    // E_start during busy is ignored; op not advancing does not issue
    run_op(3'd2, 32'd100, 32'd7, 1'b1, 1'b1, 1);
    run_op(3'd0, 32'h1234, 32'h5678, 1'b1, 1'b0, 0);
    run_op(3'd6, 32'h1234, 32'h5678, 1'b0, 1'b1, 0);

    // random mix of ops, moves and operand corners
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      op = 3'($urandom_range(0, 7));
      if (op > 3'd4 && $urandom_range(0, 1) == 0) op = 3'($urandom_range(0, 4));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      run_op(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
             ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
